// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle: the held word, its error flags, and the overrun pulse.
// The master modport is the receiver side. The slave modport is the consumer side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_error, frame_error, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_error, frame_error, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a one-word holding register and a valid/ready handshake.
// Optional macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rxd,
  uart_rx_cfg_if.master rx
);
  localparam int BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int MID     = BIT_CYC >> 1;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST  = CW'(BIT_CYC - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] SAMP  = CW'(MID + 1);
`else
  localparam logic [CW-1:0] SAMP  = CW'(MID);
`endif
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic          SLAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rxd_s1, rxd_s, rxd_d;
  logic                 bit_val;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err, done;

  // rxd_d keeps the previous synchronized value for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s  <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s  <= rxd_s1;
      rxd_d  <= rxd_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist holds the samples taken at MID-1 and MID. The vote is taken at MID+1.
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxd_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          if (rxd_d && !rxd_s) begin
            state   <= S_START;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        S_START: begin
          // A start bit that reads high at its sample point is a glitch and is dropped silently.
          if (cnt == SAMP && bit_val) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == SAMP) shreg[bit_cnt] <= bit_val;
          if (cnt == LAST) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == DLAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (cnt == SAMP) par_err <= (((^shreg) ^ bit_val) != (PARITY == 1));
          if (cnt == LAST) state <= S_STOP;
        end
        S_STOP: begin
          if (cnt == SAMP) begin
            if (!bit_val) frm_err <= 1'b1;
            // Leave at the last stop sample so a new start edge is caught early.
            if (stop_cnt == SLAST) begin
              state <= S_IDLE;
              cnt   <= '0;
              done  <= 1'b1;
            end
          end
          if (cnt == LAST) stop_cnt <= stop_cnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register. A completed frame that arrives while a word is held and not
  // accepted is dropped, and the drop is reported with a one-cycle overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.rx_data      <= '0;
      rx.rx_valid     <= 1'b0;
      rx.parity_error <= 1'b0;
      rx.frame_error  <= 1'b0;
      rx.overrun      <= 1'b0;
    end else begin
      rx.overrun <= 1'b0;
      if (done && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data      <= shreg;
        rx.parity_error <= par_err;
        rx.frame_error  <= frm_err;
        rx.rx_valid     <= 1'b1;
      end else if (done) begin
        rx.overrun <= 1'b1;
      end else if (rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end
endmodule
